id_stage_pipe: RTL

//  Parametrised MIPS-style decode stage, successor to the single-issue ID block.

---
 rtl/id_stage_pipe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS-style decode stage with register file, ID-stage branch resolution,
// EX/MEM/WB operand forwarding, load-use stall FSM and a registered ID/EX bundle.
//
// Optional feature macro: ID_MEM_FWD_EN
//   defined     -> MEM-stage results are forwarded into ID operands.
//   not defined -> no MEM forwarding; a used operand matching the MEM destination
//                  stalls one extra cycle (counted in o_stall_cnt).
//
// Ports:
//   i_clk, i_rst_n                     clock (rising edge), asynchronous active-low reset
//   i_if_valid/i_if_pc/i_if_instr      IF/ID register contents (pc is PC+4)
//   o_id_ready                         ID accepts the IF/ID instruction this cycle
//   i_ex_ready                         EX accepts the ID/EX register this cycle
//   i_ex_we/i_ex_rd/i_ex_data          EX write intent, destination, ALU result
//   i_ex_is_load                       EX instruction is a load (data not yet valid)
//   i_mem_we/i_mem_rd/i_mem_data       MEM write intent, destination, result
//   i_wb_we/i_wb_rd/i_wb_data          register-file write port
//   o_id_valid ... o_id_rd             registered ID/EX bundle
//   o_br_taken/o_br_target             combinational redirect for beq/bne/j
//   o_stall_cnt                        saturating count of load-use stall cycles
module id_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_if_valid,
  input  logic [XLEN-1:0]  i_if_pc,
  input  logic [31:0]      i_if_instr,
  output logic             o_id_ready,
  input  logic             i_ex_ready,
  input  logic             i_ex_we,
  input  logic [RA_W-1:0]  i_ex_rd,
  input  logic [XLEN-1:0]  i_ex_data,
  input  logic             i_ex_is_load,
  input  logic             i_mem_we,
  input  logic [RA_W-1:0]  i_mem_rd,
  input  logic [XLEN-1:0]  i_mem_data,
  input  logic             i_wb_we,
  input  logic [RA_W-1:0]  i_wb_rd,
  input  logic [XLEN-1:0]  i_wb_data,
  output logic             o_id_valid,
  output logic [XLEN-1:0]  o_id_pc,
  output logic [XLEN-1:0]  o_id_bus_a,
  output logic [XLEN-1:0]  o_id_bus_b,
  output logic [XLEN-1:0]  o_id_imm,
  output logic [5:0]       o_id_opcode,
  output logic [5:0]       o_id_func,
  output logic [RA_W-1:0]  o_id_rs,
  output logic [RA_W-1:0]  o_id_rt,
  output logic [RA_W-1:0]  o_id_rd,
  output logic             o_br_taken,
  output logic [XLEN-1:0]  o_br_target,
  output logic [CNT_W-1:0] o_stall_cnt
);
  typedef enum logic [1:0] {S_RUN, S_STALL, S_HOLD} state_t;
  state_t           r_state;
  logic [XLEN-1:0]  r_rf [NREG];
  logic             r_id_valid;
  logic [XLEN-1:0]  r_id_pc, r_id_bus_a, r_id_bus_b, r_id_imm;
  logic [5:0]       r_id_opcode, r_id_func;
  logic [RA_W-1:0]  r_id_rs, r_id_rt, r_id_rd;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [5:0]       w_op, w_func;
  logic [RA_W-1:0]  w_rs, w_rt, w_rd;
  logic [15:0]      w_imm16;
  logic [XLEN-1:0]  w_sext, w_imm, w_bus_a, w_bus_b, w_br_tgt, w_j_tgt;
  logic             w_use_rs, w_use_rt, w_hz, w_hold_req, w_id_ready;
  assign w_op    = i_if_instr[31:26];
  assign w_rs    = i_if_instr[25:21];
  assign w_rt    = i_if_instr[20:16];
  assign w_rd    = i_if_instr[15:11];
  assign w_func  = i_if_instr[5:0];
  assign w_imm16 = i_if_instr[15:0];
  assign w_use_rs = w_op != 6'd2;
  assign w_use_rt = w_op == 6'd0 || w_op == 6'd4 || w_op == 6'd5 || w_op == 6'd43;
  // True when a nonzero register index is read by the instruction in IF/ID.
  function automatic logic uses(input logic [RA_W-1:0] a);
    return (a != '0) && ((w_use_rs && w_rs == a) || (w_use_rt && w_rt == a));
  endfunction
  // Operand source priority: EX result > MEM result > WB write > register file; r0 is always 0.
  function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] a);
    if (a == '0) return '0;
    if (i_ex_we && !i_ex_is_load && i_ex_rd == a) return i_ex_data;
`ifdef ID_MEM_FWD_EN
    if (i_mem_we && i_mem_rd == a) return i_mem_data;
`endif
    if (i_wb_we && i_wb_rd == a) return i_wb_data;
    return r_rf[a];
  endfunction
  assign w_bus_a = fwd(w_rs);
  assign w_bus_b = fwd(w_rt);
`ifdef ID_MEM_FWD_EN
  assign w_hz = i_if_valid && i_ex_is_load && i_ex_we && uses(i_ex_rd);
`else
  // Without MEM forwarding, a pending MEM result must reach WB before it can be read.
  assign w_hz = i_if_valid && ((i_ex_is_load && i_ex_we && uses(i_ex_rd)) ||
                               (i_mem_we && uses(i_mem_rd)));
  logic w_unused;
  assign w_unused = ^i_mem_data;
`endif
  assign w_sext   = {{(XLEN-16){w_imm16[15]}}, w_imm16};
  assign w_imm    = (w_op == 6'd12 || w_op == 6'd13) ? {{(XLEN-16){1'b0}}, w_imm16} : w_sext;
  assign w_br_tgt = i_if_pc + (w_sext << 2);
  assign w_j_tgt  = {i_if_pc[XLEN-1:28], i_if_instr[25:0], 2'b00};
  // A live ID/EX entry that EX refuses must stay put, so ID cannot take a new one.
  assign w_hold_req = r_id_valid && !i_ex_ready;
  assign w_id_ready = (r_state != S_HOLD) && i_ex_ready && !w_hz;
  assign o_id_ready  = w_id_ready;
  assign o_br_target = (w_op == 6'd2) ? w_j_tgt : w_br_tgt;
  assign o_br_taken  = i_if_valid && w_id_ready &&
                       ((w_op == 6'd4 && w_bus_a == w_bus_b) ||
                        (w_op == 6'd5 && w_bus_a != w_bus_b) ||
                        (w_op == 6'd2));
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (i_wb_we && i_wb_rd != '0) begin
      r_rf[i_wb_rd] <= i_wb_data;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_RUN;
      r_id_valid  <= 1'b0;
      r_id_pc     <= '0;
      r_id_bus_a  <= '0;
      r_id_bus_b  <= '0;
      r_id_imm    <= '0;
      r_id_opcode <= '0;
      r_id_func   <= '0;
      r_id_rs     <= '0;
      r_id_rt     <= '0;
      r_id_rd     <= '0;
      r_stall_cnt <= '0;
    end else begin
      // HOLD takes precedence over a hazard; the hazard is re-evaluated once HOLD exits.
      r_state <= (r_state == S_HOLD) ? (i_ex_ready ? S_RUN : S_HOLD) :
                 w_hold_req ? S_HOLD : w_hz ? S_STALL : S_RUN;
      if (r_state != S_HOLD && !w_hold_req && w_hz && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (i_ex_ready && r_state != S_HOLD) begin
        r_id_valid  <= i_if_valid && w_id_ready;
        r_id_pc     <= i_if_pc;
        r_id_bus_a  <= w_bus_a;
        r_id_bus_b  <= w_bus_b;
        r_id_imm    <= w_imm;
        r_id_opcode <= w_op;
        r_id_func   <= w_func;
        r_id_rs     <= w_rs;
        r_id_rt     <= w_rt;
        r_id_rd     <= w_rd;
      end
    end
  end
  assign o_id_valid  = r_id_valid;
  assign o_id_pc     = r_id_pc;
  assign o_id_bus_a  = r_id_bus_a;
  assign o_id_bus_b  = r_id_bus_b;
  assign o_id_imm    = r_id_imm;
  assign o_id_opcode = r_id_opcode;
  assign o_id_func   = r_id_func;
  assign o_id_rs     = r_id_rs;
  assign o_id_rt     = r_id_rt;
  assign o_id_rd     = r_id_rd;
  assign o_stall_cnt = r_stall_cnt;
endmodule
